// File: rtl/i2c_txn_sequencer_if.sv
// Host request, engine command/response and completion signals of the I2C transaction sequencer.
// The master modport is the sequencer's view; slave is the host/engine side.
interface i2c_txn_sequencer_if #(
  parameter int unsigned CMD_W = 2
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_rd;
  logic [6:0]       req_dev;
  logic [7:0]       req_reg;
  logic [7:0]       req_wdata;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_op;
  logic [7:0]       cmd_data;
  logic             cmd_mack;
  logic             rsp_valid;
  logic             rsp_ack;
  logic [7:0]       rsp_data;
  logic             engine_abort;
  logic             done_valid;
  logic [1:0]       done_status;
  logic [7:0]       done_rdata;

  modport master (
    input  req_valid, req_rd, req_dev, req_reg, req_wdata, cmd_ready, rsp_valid, rsp_ack,
           rsp_data,
    output req_ready, cmd_valid, cmd_op, cmd_data, cmd_mack, engine_abort, done_valid,
           done_status, done_rdata
  );

  modport slave (
    output req_valid, req_rd, req_dev, req_reg, req_wdata, cmd_ready, rsp_valid, rsp_ack,
           rsp_data,
    input  req_ready, cmd_valid, cmd_op, cmd_data, cmd_mack, engine_abort, done_valid,
           done_status, done_rdata
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Turns one I2C register read/write request into START/WRITE/READ/STOP byte-engine commands,
// handling slave NACK and per-command engine timeout, and reports a single completion.
module i2c_txn_sequencer #(
  parameter int unsigned TIMEOUT = 16'hFFFF,
  parameter int unsigned CMD_W   = 2
) (
  input logic                clk,
  input logic                rst_n,
  i2c_txn_sequencer_if.master bus_io
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StStart  = 4'd1;
  localparam logic [3:0] StAddrW  = 4'd2;
  localparam logic [3:0] StReg    = 4'd3;
  localparam logic [3:0] StWdata  = 4'd4;
  localparam logic [3:0] StRstart = 4'd5;
  localparam logic [3:0] StAddrR  = 4'd6;
  localparam logic [3:0] StRead   = 4'd7;
  localparam logic [3:0] StStop   = 4'd8;
  localparam logic [3:0] StDone   = 4'd9;

  localparam logic [CMD_W-1:0] OpStart = CMD_W'(0);
  localparam logic [CMD_W-1:0] OpWrite = CMD_W'(1);
  localparam logic [CMD_W-1:0] OpRead  = CMD_W'(2);
  localparam logic [CMD_W-1:0] OpStop  = CMD_W'(3);

  localparam logic [1:0] StsOk      = 2'd0;
  localparam logic [1:0] StsNack    = 2'd1;
  localparam logic [1:0] StsTimeout = 2'd2;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  logic [3:0]  state_q, state_d;
  logic        wait_q, wait_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cmd_state;
  logic        timeout_hit;

  always_comb begin
    cmd_state = (state_q >= StStart) && (state_q <= StStop);
    // A response in the last allowed cycle beats the timeout.
    timeout_hit = cmd_state && wait_q && !bus_io.rsp_valid && (cnt_q == CntLast);

    bus_io.req_ready    = (state_q == StIdle);
    bus_io.cmd_valid    = cmd_state && !wait_q;
    bus_io.cmd_mack     = 1'b1;
    bus_io.engine_abort = timeout_hit;
    bus_io.done_valid   = (state_q == StDone);
    bus_io.done_status  = status_q;
    bus_io.done_rdata   = rdata_q;

    bus_io.cmd_op   = OpStart;
    bus_io.cmd_data = 8'h00;
    case (state_q)
      StAddrW: begin
        bus_io.cmd_op   = OpWrite;
        bus_io.cmd_data = {dev_q, 1'b0};
      end
      StReg: begin
        bus_io.cmd_op   = OpWrite;
        bus_io.cmd_data = reg_q;
      end
      StWdata: begin
        bus_io.cmd_op   = OpWrite;
        bus_io.cmd_data = wdata_q;
      end
      StAddrR: begin
        bus_io.cmd_op   = OpWrite;
        bus_io.cmd_data = {dev_q, 1'b1};
      end
      StRead:  bus_io.cmd_op = OpRead;
      StStop:  bus_io.cmd_op = OpStop;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    status_d = status_q;
    rdata_d  = rdata_q;

    case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          rd_d     = bus_io.req_rd;
          dev_d    = bus_io.req_dev;
          reg_d    = bus_io.req_reg;
          wdata_d  = bus_io.req_wdata;
          status_d = StsOk;
          rdata_d  = 8'h00;
          wait_d   = 1'b0;
          state_d  = StStart;
        end
      end
      StStart, StAddrW, StReg, StWdata, StRstart, StAddrR, StRead, StStop: begin
        if (!wait_q) begin
          if (bus_io.cmd_ready) begin
            wait_d = 1'b1;
            cnt_d  = 16'd0;
          end
        end else if (bus_io.rsp_valid) begin
          wait_d = 1'b0;
          case (state_q)
            StStart:  state_d = StAddrW;
            StAddrW:  state_d = bus_io.rsp_ack ? StReg : StStop;
            StReg:    state_d = !bus_io.rsp_ack ? StStop : (rd_q ? StRstart : StWdata);
            StWdata:  state_d = StStop;
            StRstart: state_d = StAddrR;
            StAddrR:  state_d = bus_io.rsp_ack ? StRead : StStop;
            StRead: begin
              rdata_d = bus_io.rsp_data;
              state_d = StStop;
            end
            default:  state_d = StDone;
          endcase
          // Any NACKed WRITE skips the remaining bytes and goes straight to STOP.
          if ((bus_io.cmd_op == OpWrite) && !bus_io.rsp_ack) begin
            status_d = StsNack;
          end
        end else if (timeout_hit) begin
          wait_d   = 1'b0;
          status_d = StsTimeout;
          rdata_d  = 8'h00;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wait_q   <= 1'b0;
      cnt_q    <= 16'd0;
      rd_q     <= 1'b0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      wdata_q  <= 8'd0;
      status_q <= StsOk;
      rdata_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: the bench plays host and byte engine, and compares every
// transaction against a command-list model of the register read/write protocol.
module tb_i2c_txn_sequencer;

  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int         exp_ops[$];
  logic [7:0] exp_wdat[$];
  int         exp_status;
  logic [7:0] exp_rdata;
  int         exp_abort;

  i2c_txn_sequencer_if #(.CMD_W(2)) bus ();

  i2c_txn_sequencer #(
    .TIMEOUT(TO),
    .CMD_W  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
    chk({tag, "_cmd_op"}, 32'(bus.cmd_op), 32'd0);
    chk({tag, "_cmd_data"}, 32'(bus.cmd_data), 32'd0);
    chk({tag, "_cmd_mack"}, 32'(bus.cmd_mack), 32'd1);
    chk({tag, "_abort"}, 32'(bus.engine_abort), 32'd0);
    chk({tag, "_done_valid"}, 32'(bus.done_valid), 32'd0);
    chk({tag, "_done_status"}, 32'(bus.done_status), 32'd0);
    chk({tag, "_done_rdata"}, 32'(bus.done_rdata), 32'd0);
  endtask

  // Protocol model: full command list, cut short by a NACK (jump to STOP) or timeout (stop there).
  function automatic void build_model(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                                      input logic [7:0] wd, input logic [7:0] rbyte,
                                      input int nack_w, input int to_c);
    int         ops[$];
    logic [7:0] dat[$];
    bit         skip;
    int         widx;
    if (!rd) begin
      ops = '{0, 1, 1, 1, 3};
      dat = '{8'h00, {dev, 1'b0}, rg, wd, 8'h00};
    end else begin
      ops = '{0, 1, 1, 0, 1, 2, 3};
      dat = '{8'h00, {dev, 1'b0}, rg, 8'h00, {dev, 1'b1}, 8'h00, 8'h00};
    end
    exp_ops.delete();
    exp_wdat.delete();
    exp_status = 0;
    exp_abort  = 0;
    skip       = 1'b0;
    widx       = 0;
    foreach (ops[i]) begin
      if (skip && ops[i] != 3) continue;
      exp_ops.push_back(ops[i]);
      if (ops[i] == 1) exp_wdat.push_back(dat[i]);
      if (exp_ops.size() - 1 == to_c) begin
        exp_status = 2;
        exp_abort  = 1;
        break;
      end
      if (ops[i] == 1) begin
        if (widx == nack_w) begin
          exp_status = 1;
          skip       = 1'b1;
        end
        widx++;
      end
    end
    exp_rdata = (exp_status == 0 && rd) ? rbyte : 8'h00;
  endfunction

  // One transaction: host request then the engine role, cycle by cycle.
  // nack_w: index of the WRITE to NACK; to_c: command never answered; fix_c/fix_lat: forced
  // response latency; hold: cycles cmd_ready stays low; rst_c: reset while this command waits.
  task automatic run_txn(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rbyte, input int nack_w,
                         input int to_c, input int fix_c, input int fix_lat, input int hold,
                         input int rst_c);
    int         got_ops[$];
    logic [7:0] got_wdat[$];
    bit         done, outstanding, prev_pend, resp_prev, real_rsp, pend_start, rst_armed;
    int         age, lat, hs, nwr, cur_op, cur_w, wait_rdy, aborts;
    int         prev_op;
    logic [7:0] prev_data;
    logic [1:0] got_status;
    logic [7:0] got_rdata;

    build_model(rd, dev, rg, wd, rbyte, nack_w, to_c);
    done = 0; outstanding = 0; prev_pend = 0; resp_prev = 0; rst_armed = 0;
    age = 0; lat = 0; hs = 0; nwr = 0; cur_op = 0; cur_w = 0; wait_rdy = 0; aborts = 0;
    prev_op = 0; prev_data = 0; got_status = 0; got_rdata = 0;

    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    bus.rsp_valid = 1'b0;
    bus.cmd_ready = 1'b0;
    #1;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    chk("done_one_cycle", 32'(bus.done_valid), 32'd0);
    @(posedge clk);

    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc > 0) @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_rd    = 1'($urandom);
      bus.req_dev   = 7'($urandom);
      bus.req_reg   = 8'($urandom);
      bus.req_wdata = 8'($urandom);
      bus.rsp_valid = 1'b0;
      bus.rsp_ack   = 1'($urandom);
      bus.rsp_data  = 8'($urandom);
      bus.cmd_ready = 1'b0;
      real_rsp      = 1'b0;
      pend_start    = outstanding;
      if (outstanding) begin
        age++;
        if (age == lat) begin
          bus.rsp_valid = 1'b1;
          real_rsp      = 1'b1;
          if (cur_op == 1) bus.rsp_ack = (cur_w != nack_w);
          if (cur_op == 2) bus.rsp_data = rbyte;
        end
      end else begin
        if ($urandom_range(0, 9) == 0) bus.rsp_valid = 1'b1;
        bus.cmd_ready = (wait_rdy >= hold);
      end
      #1;
      if (cyc == 0) chk("start_after_accept", 32'(bus.cmd_valid), 32'd1);
      if (resp_prev) chk("next_after_rsp", 32'(bus.cmd_valid | bus.done_valid), 32'd1);
      resp_prev = real_rsp;
      if (real_rsp) outstanding = 1'b0;
      if (bus.engine_abort) begin
        aborts++;
        chk("abort_age", 32'(age), 32'(TO));
        outstanding = 1'b0;
        resp_prev   = 1'b1;
      end
      if (bus.cmd_valid) begin
        chk("one_outstanding", 32'(pend_start), 32'd0);
        if (prev_pend) begin
          chk("op_stable", 32'(bus.cmd_op), 32'(prev_op));
          chk("data_stable", 32'(bus.cmd_data), 32'(prev_data));
        end
        if (bus.cmd_ready) begin
          cur_op = int'(bus.cmd_op);
          got_ops.push_back(cur_op);
          if (cur_op == 1) begin
            got_wdat.push_back(bus.cmd_data);
            cur_w = nwr;
            nwr++;
          end else begin
            chk("cmd_data_zero", 32'(bus.cmd_data), 32'd0);
          end
          if (cur_op == 2) chk("read_mack", 32'(bus.cmd_mack), 32'd1);
          if (hs == rst_c) rst_armed = 1'b1;
          lat = (hs == to_c || hs == rst_c) ? (1 << 20) :
                (hs == fix_c) ? fix_lat : int'($urandom_range(1, TO));
          hs++;
          outstanding = 1'b1;
          age         = 0;
          wait_rdy    = 0;
          prev_pend   = 1'b0;
        end else begin
          wait_rdy++;
          prev_pend = 1'b1;
          prev_op   = int'(bus.cmd_op);
          prev_data = bus.cmd_data;
        end
      end else begin
        prev_pend = 1'b0;
      end
      if (bus.done_valid) begin
        done       = 1'b1;
        got_status = bus.done_status;
        got_rdata  = bus.done_rdata;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      end
      if (rst_armed && age == 3) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        return;
      end
    end

    chk("done_seen", 32'(done), 32'd1);
    chk("n_cmds", 32'(got_ops.size()), 32'(exp_ops.size()));
    foreach (exp_ops[i]) if (i < got_ops.size()) chk("cmd_op", 32'(got_ops[i]), 32'(exp_ops[i]));
    chk("n_writes", 32'(got_wdat.size()), 32'(exp_wdat.size()));
    foreach (exp_wdat[i])
      if (i < got_wdat.size()) chk("cmd_data", 32'(got_wdat[i]), 32'(exp_wdat[i]));
    chk("done_status", 32'(got_status), 32'(exp_status));
    chk("done_rdata", 32'(got_rdata), 32'(exp_rdata));
    chk("abort_count", 32'(aborts), 32'(exp_abort));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rd    = 1'b0;
    bus.req_dev   = 7'd0;
    bus.req_reg   = 8'd0;
    bus.req_wdata = 8'd0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_ack   = 1'b0;
    bus.rsp_data  = 8'd0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, -1, 0, 0, -1);
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h5C, -1, -1, -1, 0, 0, -1);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, -1, -1, 0, 0, -1);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 2, -1, 0, 0, -1);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, 2, TO, 0, -1);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, -1, 0, 20, -1);
    run_txn(1'b1, 7'h3C, 8'h81, 8'h00, 8'hE7, 0, 2, -1, 0, 1, -1);

    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h5C, -1, -1, -1, 0, 0, 5);
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_no_done", 32'(bus.done_valid), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, -1, 0, 0, -1);

    for (int n = 0; n < 25; n++) begin
      bit rd;
      int nack_w, to_c, hold;
      rd     = 1'($urandom);
      nack_w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      to_c   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
      hold   = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 3));
      run_txn(rd, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nack_w, to_c, -1, 0,
              hold, -1);
    end

    @(posedge clk); #2;
    chk("final_idle", 32'(bus.req_ready), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Transaction-level controller sitting above the I2C bit/byte engine (the start/hold/data/stop FSM). Accepts one register-write or register-read request from the host side. Breaks it into byte-engine commands: START, WRITE, READ, STOP, with a repeated START for reads. Handles slave NACK and engine timeout, then returns a single completion with status and read data.

Parameters:
TIMEOUT, 16'hFFFF, max cycles allowed per engine command, counted from the cmd handshake to rsp_valid.
CMD_W, 2, width of the engine command code.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  sequencer can accept a request
req_rd  in  1  1 = register read, 0 = register write
req_dev  in  7  7-bit slave address
req_reg  in  8  register address
req_wdata  in  8  write data; ignored for reads
cmd_valid  out  1  engine command valid
cmd_ready  in  1  engine accepts command
cmd_op  out  CMD_W  0 = START, 1 = WRITE, 2 = READ, 3 = STOP
cmd_data  out  8  byte for WRITE, else 0
cmd_mack  out  1  master ACK level for READ; always 1 (NACK) in this block
rsp_valid  in  1  engine single-cycle completion pulse for the accepted command
rsp_ack  in  1  slave ACK observed (WRITE only)
rsp_data  in  8  byte received (READ only)
engine_abort  out  1  one-cycle pulse telling the engine to return to idle
done_valid  out  1  one-cycle transaction-complete pulse
done_status  out  2  0 = OK, 1 = NACK, 2 = TIMEOUT
done_rdata  out  8  read byte; 0 for writes and errors

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE, req_ready = 1, cmd_valid = 0, cmd_op = 0, cmd_data = 0, cmd_mack = 1, engine_abort = 0, done_valid = 0, done_status = 0, done_rdata = 0, timeout counter = 0.
- Request handshake:
  - req_valid & req_ready latches req_rd, req_dev, req_reg and req_wdata.
  - req_ready drops the same cycle and stays 0 until the cycle after done_valid.
- Command step, used by every command state:
  - Drive cmd_valid = 1 with a stable cmd_op and cmd_data until cmd_ready = 1.
  - Then drop cmd_valid, clear the counter, and wait for rsp_valid.
  - At most one command is outstanding.
  - rsp_valid while not waiting is ignored.
- Write sequence: START -> WRITE {dev,0} -> WRITE reg -> WRITE wdata -> STOP -> DONE.
- Read sequence: START -> WRITE {dev,0} -> WRITE reg -> START (repeated) -> WRITE {dev,1} -> READ (mack = 1) -> STOP -> DONE.
  - done_rdata is captured from rsp_data on the READ response.
- NACK: rsp_ack = 0 on any WRITE response -> status = 1 -> jump straight to STOP, skipping the remaining bytes -> DONE.
- Timeout:
  - The counter increments each cycle while waiting for rsp_valid.
  - When counter == TIMEOUT - 1 with no rsp_valid: pulse engine_abort, status = 2, go directly to DONE (no STOP issued).
  - The counter does not run while cmd_valid is waiting for cmd_ready.
- Timeout on the STOP command also ends in DONE with status 2. This overrides an earlier NACK status.
- rsp_valid arriving in the same cycle the timeout would fire: the response wins and no timeout is raised.
- DONE: done_valid = 1 for exactly one cycle, with done_status and done_rdata valid that cycle. Next cycle: IDLE, req_ready = 1.
- A new request may be accepted the cycle after done_valid. A back-to-back new request's START is issued one cycle after acceptance.
- rst_n asserted mid-transaction: everything returns to reset values immediately, no done_valid is produced, and engine_abort is not pulsed. The engine shares this reset.
- Response latency is engine-defined. The sequencer adds one cycle between rsp_valid and the next cmd_valid.

Test Plan:
- Write dev = 7'h50, reg = 8'h10, data = 8'hA5, engine always acks, cmd_ready immediate -> cmd_op sequence 0,1,1,1,3; cmd_data 8'hA0, 8'h10, 8'hA5; one done_valid with status 0, rdata 0; req_ready high the next cycle.
- Read dev = 7'h50, reg = 8'h22, engine returns 8'h5C -> ops 0,1,1,0,1,2,3; cmd_data 8'hA0, 8'h22, 8'hA1; cmd_mack = 1 on READ; done status 0, rdata 8'h5C.
- NACK on the address byte (rsp_ack = 0 on the first WRITE) -> next op is STOP, no further WRITEs; done status 1.
- TIMEOUT = 8, engine never responds to the second WRITE -> engine_abort pulses exactly 8 cycles after the cmd handshake, no STOP issued, done status 2. Repeat with rsp_valid in that same cycle -> no abort, sequence continues.
- cmd_ready held low 20 cycles with TIMEOUT = 8 -> cmd_valid, op and data stay stable, no timeout; completes normally.
- rst_n pulsed low while waiting on the READ response -> outputs at reset values asynchronously, no done_valid; a fresh write afterwards completes with status 0.
